// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmitter slice.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    PARITY
  } uart_state_e;

  localparam logic IDLE_LEVEL = 1'b1;

  function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
    return clk_hz / bit_rate;
  endfunction

endpackage

// File: rtl/uart_tx_baud.sv
// Bit-period timer: emits a one-cycle bit_done pulse at the last cycle of each bit period.
module uart_tx_baud
  import uart_pkg::*;
#(
  parameter int CYCLES_PER_BIT = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  output logic bit_done
);

  localparam int CW = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES_PER_BIT - 1);

  logic [CW-1:0] count;

  // NOTE: sequential state is always written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      count <= '0;
    end else if (clear || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign bit_done = (count == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional even parity, one stop bit.
// Define UART_TX_PARITY_EN to insert the even-parity bit between data and stop.
module uart_tx
  import uart_pkg::*;
#(
  parameter int BIT_RATE     = 9600,
  parameter int PAYLOAD_BITS = 8,
  parameter int CLK_HZ       = 50_000_000
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    uart_tx_en,
  input  logic [PAYLOAD_BITS-1:0] uart_tx_data,
  output logic                    uart_tx_busy,
  output logic                    uart_txd
);

  localparam int CYCLES_PER_BIT = cycles_per_bit(CLK_HZ, BIT_RATE);
  localparam int IW = $clog2(PAYLOAD_BITS + 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(PAYLOAD_BITS - 1);

  uart_state_e             state;
  logic [PAYLOAD_BITS-1:0] shift_reg;
  logic [PAYLOAD_BITS-1:0] shift_next;
  logic [IW-1:0]           bit_idx;
  logic                    bit_done;
`ifdef UART_TX_PARITY_EN
  logic                    parity_bit;
`endif

  assign shift_next = shift_reg >> 1;

  // The timer is held at zero while idle, so acceptance doubles as the frame-start clear.
  uart_tx_baud #(
    .CYCLES_PER_BIT(CYCLES_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (state == IDLE),
    .bit_done(bit_done)
  );

  // NOTE: the data register is reset too, so nothing stale is ever shifted onto the line.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state        <= IDLE;
      shift_reg    <= '0;
      bit_idx      <= '0;
      uart_txd     <= IDLE_LEVEL;
      uart_tx_busy <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (uart_tx_en) begin
            shift_reg    <= uart_tx_data;
            bit_idx      <= '0;
            uart_txd     <= 1'b0;
            uart_tx_busy <= 1'b1;
            state        <= START;
`ifdef UART_TX_PARITY_EN
            parity_bit   <= ^uart_tx_data;
`endif
          end
        end
        START: begin
          if (bit_done) begin
            bit_idx  <= '0;
            uart_txd <= shift_reg[0];
            state    <= DATA;
          end
        end
        DATA: begin
          if (bit_done) begin
            if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              uart_txd <= parity_bit;
              state    <= PARITY;
`else
              uart_txd <= IDLE_LEVEL;
              state    <= STOP;
`endif
            end else begin
              shift_reg <= shift_next;
              bit_idx   <= bit_idx + 1'b1;
              uart_txd  <= shift_next[0];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_done) begin
            uart_txd <= IDLE_LEVEL;
            state    <= STOP;
          end
        end
`endif
        STOP: begin
          if (bit_done) begin
            uart_tx_busy <= 1'b0;
            state        <= IDLE;
          end
        end
        default: begin
          uart_txd     <= IDLE_LEVEL;
          uart_tx_busy <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx against a bit-period frame model (honours UART_TX_PARITY_EN).
module tb_uart_tx;

  localparam int CLK_HZ   = 1_000_000;
  localparam int BIT_RATE = 100_000;
  localparam int PB       = 8;
  localparam int CPB      = CLK_HZ / BIT_RATE;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = PB + 3;
`else
  localparam int NBITS = PB + 2;
`endif
  localparam int FRAME = NBITS * CPB;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          en = 1'b0;
  logic [PB-1:0] data = '0;
  logic          busy;
  logic          txd;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_tx #(
    .BIT_RATE    (BIT_RATE),
    .PAYLOAD_BITS(PB),
    .CLK_HZ      (CLK_HZ)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .uart_tx_en  (en),
    .uart_tx_data(data),
    .uart_tx_busy(busy),
    .uart_txd    (txd)
  );

  // Line level at cycle k of a frame carrying d: bit slot k/CPB of start, data LSB-first, [parity], stop.
  function automatic logic model_txd(input logic [PB-1:0] d, input int k);
    int slot;
    slot = k / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= PB) return d[slot-1];
    if (NBITS == PB + 3 && slot == PB + 1) return ^d;
    return 1'b1;
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // Called at the negedge where en is set; returns at the negedge of frame cycle 0.
  task automatic send(input logic [PB-1:0] d);
    en   = 1'b1;
    data = d;
    @(negedge clk);
  endtask

  // Entered at the negedge of frame cycle 0; checks cycles [0, stop_at) and, for a full
  // frame, the first idle cycle afterwards (left positioned on that negedge).
  task automatic run_frame(input logic [PB-1:0] d, input int stop_at, input int poke_at,
                           input logic hold_en, input logic [PB-1:0] next_data);
    for (int k = 0; k < stop_at; k++) begin
      check($sformatf("txd[%02h]@%0d", d, k), txd, model_txd(d, k));
      check($sformatf("busy[%02h]@%0d", d, k), busy, 1'b1);
      if (k == 0 && !hold_en) en = 1'b0;
      if (k == 1) data = next_data;
      if (poke_at >= 0 && k == poke_at) begin
        en   = 1'b1;
        data = '1;
      end
      if (poke_at >= 0 && k == poke_at + 1) en = 1'b0;
      @(negedge clk);
    end
    if (stop_at == FRAME) begin
      check($sformatf("idle_txd[%02h]", d), txd, 1'b1);
      check($sformatf("idle_busy[%02h]", d), busy, 1'b0);
    end
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [PB-1:0] d;

    // Power-on reset, asserted asynchronously before any clock edge.
    #1 resetn = 1'b1;
    #1;
    check("por_txd", txd, 1'b1);
    check("por_busy", busy, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("por_hold_txd", txd, 1'b1);
      check("por_hold_busy", busy, 1'b0);
    end
    resetn = 1'b0;
    @(negedge clk);

    // Single frame 0xA5.
    send(8'hA5);
    run_frame(8'hA5, FRAME, -1, 1'b0, 8'($urandom));

    // Request at cycle 40 of a frame is dropped, and nothing follows the frame.
    send(8'h3C);
    run_frame(8'h3C, FRAME, 40, 1'b0, 8'($urandom));
    for (int k = 0; k < 2 * FRAME; k++) begin
      if (k % CPB == 0) begin
        check($sformatf("no_queue_txd@%0d", k), txd, 1'b1);
        check($sformatf("no_queue_busy@%0d", k), busy, 1'b0);
      end
      @(negedge clk);
    end

    // Back-to-back with en held: one idle cycle between frames.
    send(8'h00);
    run_frame(8'h00, FRAME, -1, 1'b1, 8'hFF);
    @(negedge clk);
    run_frame(8'hFF, FRAME, -1, 1'b0, 8'($urandom));

    // Asynchronous reset in the middle of a data bit.
    send(8'h81);
    run_frame(8'h81, 55, -1, 1'b0, 8'($urandom));
    check("pre_rst_txd", txd, model_txd(8'h81, 55));
    #1 resetn = 1'b1;
    #1;
    check("mid_rst_txd", txd, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("mid_rst_hold_txd", txd, 1'b1);
      check("mid_rst_hold_busy", busy, 1'b0);
    end
    resetn = 1'b0;
    @(negedge clk);
    check("post_rst_idle_txd", txd, 1'b1);
    d = 8'($urandom);
    send(d);
    run_frame(d, FRAME, -1, 1'b0, 8'($urandom));

    // Random words separated by random idle gaps.
    for (int n = 0; n < 4; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      d = 8'($urandom);
      send(d);
      run_frame(d, FRAME, -1, 1'b0, 8'($urandom));
    end

`ifdef UART_TX_PARITY_EN
    send(8'h07);
    run_frame(8'h07, FRAME, -1, 1'b0, 8'($urandom));
    send(8'h03);
    run_frame(8'h03, FRAME, -1, 1'b0, 8'($urandom));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
